// File: rtl/uart_cmd_ctrl.sv
// UART command-frame controller: parses SYNC/CMD/[DATA]/CHK frames from received bytes
// and issues one-cycle register write/read strobes, with inter-byte timeout and error count.

module uart_cmd_ctrl #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 21700
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    output logic       o_Wr_En,
    output logic [3:0] o_Wr_Addr,
    output logic [7:0] o_Wr_Data,
    output logic       o_Rd_En,
    output logic [3:0] o_Rd_Addr,
    output logic       o_Busy,
    output logic       o_Err_Pulse,
    output logic [7:0] o_Err_Count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2,
        ST_CHK  = 2'd3
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CLKS - 32'd1);

    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

    state_t      state_q,     state_d;
    logic        prev_dv_q,   prev_dv_d;
    logic [15:0] tmo_q,       tmo_d;
    logic [7:0]  chk_q,       chk_d;
    logic        is_wr_q,     is_wr_d;
    logic [3:0]  addr_q,      addr_d;
    logic [7:0]  data_q,      data_d;
    logic        wr_en_q,     wr_en_d;
    logic [3:0]  wr_addr_q,   wr_addr_d;
    logic [7:0]  wr_data_q,   wr_data_d;
    logic        rd_en_q,     rd_en_d;
    logic [3:0]  rd_addr_q,   rd_addr_d;
    logic        busy_q,      busy_d;
    logic        err_pulse_q, err_pulse_d;
    logic [7:0]  err_cnt_q,   err_cnt_d;

    logic accept_s;
    logic timeout_s;
    logic error_s;

    // An accept is the rising edge of DV; the previous-DV flop resets high so a held byte is ignored.
    assign accept_s  = i_RX_DV & ~prev_dv_q;
    assign timeout_s = (state_q != ST_IDLE) && (tmo_q == TMO_LAST) && !accept_s;

    // Next-state, datapath and output computation for the frame sequencer
    always_comb begin
        state_d     = state_q;
        prev_dv_d   = i_RX_DV;
        chk_d       = chk_q;
        is_wr_d     = is_wr_q;
        addr_d      = addr_q;
        data_d      = data_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        error_s     = 1'b0;

        if (accept_s || (state_q == ST_IDLE) || timeout_s) begin
            tmo_d = 16'd0;
        end else begin
            tmo_d = tmo_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_s && (i_RX_Byte == SYNC_BYTE)) begin
                    state_d = ST_CMD;
                    chk_d   = SYNC_BYTE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (accept_s) begin
                    if (i_RX_Byte[6:4] != 3'd0) begin
                        error_s = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        is_wr_d = i_RX_Byte[7];
                        addr_d  = i_RX_Byte[3:0];
                        chk_d   = chk_fold(chk_q, i_RX_Byte);
                        state_d = i_RX_Byte[7] ? ST_DATA : ST_CHK;
                    end
                end else begin
                    state_d = ST_CMD;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
                    data_d  = i_RX_Byte;
                    chk_d   = chk_fold(chk_q, i_RX_Byte);
                    state_d = ST_CHK;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_CHK: begin
                if (accept_s) begin
                    if (i_RX_Byte == chk_q) begin
                        if (is_wr_q) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = data_q;
                        end else begin
                            rd_en_d   = 1'b1;
                            rd_addr_d = addr_q;
                        end
                    end else begin
                        error_s = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CHK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Timeout never coincides with an accept, so it cannot collide with the case above.
        if (timeout_s) begin
            error_s = 1'b1;
            state_d = ST_IDLE;
        end else begin
            error_s = error_s;
        end

        err_pulse_d = error_s;
        if (error_s) begin
            err_cnt_d = sat_inc8(err_cnt_q);
        end else begin
            err_cnt_d = err_cnt_q;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q     <= ST_IDLE;
            prev_dv_q   <= 1'b1;
            tmo_q       <= 16'd0;
            chk_q       <= 8'd0;
            is_wr_q     <= 1'b0;
            addr_q      <= 4'd0;
            data_q      <= 8'd0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 4'd0;
            wr_data_q   <= 8'd0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= 4'd0;
            busy_q      <= 1'b0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            prev_dv_q   <= prev_dv_d;
            tmo_q       <= tmo_d;
            chk_q       <= chk_d;
            is_wr_q     <= is_wr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            busy_q      <= busy_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign o_Wr_En     = wr_en_q;
    assign o_Wr_Addr   = wr_addr_q;
    assign o_Wr_Data   = wr_data_q;
    assign o_Rd_En     = rd_en_q;
    assign o_Rd_Addr   = rd_addr_q;
    assign o_Busy      = busy_q;
    assign o_Err_Pulse = err_pulse_q;
    assign o_Err_Count = err_cnt_q;

    uart_cmd_ctrl_chk u_chk (
        .clk       (i_Clock),
        .rst       (i_Reset),
        .wr_en     (wr_en_q),
        .rd_en     (rd_en_q),
        .err_pulse (err_pulse_q),
        .busy      (busy_q),
        .err_cnt   (err_cnt_q)
    );

endmodule

// Output invariants: strobes/errors are exclusive and always end the frame.
module uart_cmd_ctrl_chk (
    input logic       clk,
    input logic       rst,
    input logic       wr_en,
    input logic       rd_en,
    input logic       err_pulse,
    input logic       busy,
    input logic [7:0] err_cnt
);

    a_excl: assert property (@(posedge clk) disable iff (rst) $onehot0({wr_en, rd_en, err_pulse}));
    a_idle: assert property (@(posedge clk) disable iff (rst) (wr_en || rd_en || err_pulse) |-> !busy);
    a_cnt:  assert property (@(posedge clk) disable iff (rst) err_pulse |-> (err_cnt != 8'd0));

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: frame table, hand-written corner sequences and random byte
// streams, all checked every cycle against a frame-queue reference model.

module tb_uart_cmd_ctrl;

    localparam int         TMO  = 400;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       i_Reset;
    logic       i_RX_DV;
    logic [7:0] i_RX_Byte;
    logic       o_Wr_En, o_Rd_En, o_Busy, o_Err_Pulse;
    logic [3:0] o_Wr_Addr, o_Rd_Addr;
    logic [7:0] o_Wr_Data, o_Err_Count;

    always #5 clk = ~clk;

    uart_cmd_ctrl #(.SYNC_BYTE(SYNC), .TIMEOUT_CLKS(TMO)) dut (
        .i_Clock     (clk),
        .i_Reset     (i_Reset),
        .i_RX_DV     (i_RX_DV),
        .i_RX_Byte   (i_RX_Byte),
        .o_Wr_En     (o_Wr_En),
        .o_Wr_Addr   (o_Wr_Addr),
        .o_Wr_Data   (o_Wr_Data),
        .o_Rd_En     (o_Rd_En),
        .o_Rd_Addr   (o_Rd_Addr),
        .o_Busy      (o_Busy),
        .o_Err_Pulse (o_Err_Pulse),
        .o_Err_Count (o_Err_Count)
    );

    int checks = 0;
    int failures = 0;
    int wr_seen = 0, rd_seen = 0, err_seen = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    // Reference model: bytes of the current frame are kept in a queue and judged as a whole.
    logic [7:0] frm[$];
    bit         m_prev = 1'b1;
    int         m_since = 0;
    logic       m_wr = 1'b0, m_rd = 1'b0, m_err = 1'b0, m_busy = 1'b0;
    logic [3:0] m_wa = 4'd0, m_ra = 4'd0;
    logic [7:0] m_wd = 8'd0, m_cnt = 8'd0;

    task automatic model_step(input logic rst, input logic dv, input logic [7:0] b);
        logic [7:0] x;
        int         len;
        bit         acc, err;
        m_wr = 1'b0; m_rd = 1'b0; m_err = 1'b0; err = 1'b0;
        if (rst) begin
            frm.delete();
            m_prev = 1'b1; m_since = 0; m_busy = 1'b0;
            m_wa = 4'd0; m_wd = 8'd0; m_ra = 4'd0; m_cnt = 8'd0;
            return;
        end
        acc = dv && !m_prev;
        m_prev = dv;
        if (acc) begin
            m_since = 0;
            if (frm.size() == 0) begin
                if (b == SYNC) frm.push_back(b);
            end else begin
                frm.push_back(b);
                if (frm.size() == 2 && b[6:4] != 3'd0) begin
                    err = 1'b1;
                    frm.delete();
                end else begin
                    len = frm[1][7] ? 4 : 3;
                    if (frm.size() == len) begin
                        x = 8'h00;
                        for (int i = 0; i < len - 1; i++) x ^= frm[i];
                        if (x == frm[len-1]) begin
                            if (len == 4) begin
                                m_wr = 1'b1; m_wa = frm[1][3:0]; m_wd = frm[2];
                            end else begin
                                m_rd = 1'b1; m_ra = frm[1][3:0];
                            end
                        end else begin
                            err = 1'b1;
                        end
                        frm.delete();
                    end
                end
            end
        end else if (frm.size() > 0) begin
            m_since++;
            if (m_since == TMO) begin
                err = 1'b1;
                frm.delete();
            end
        end
        if (err) begin
            m_err = 1'b1;
            if (m_cnt != 8'd255) m_cnt++;
        end
        m_busy = (frm.size() > 0);
    endtask

    // Model steps on the sampling edge; DUT outputs compared on the opposite edge.
    initial begin
        forever begin
            @(posedge clk);
            model_step(i_Reset, i_RX_DV, i_RX_Byte);
            @(negedge clk);
            check("cycle",
                  32'({o_Wr_En, o_Rd_En, o_Err_Pulse, o_Busy, o_Wr_Addr, o_Wr_Data, o_Rd_Addr, o_Err_Count}),
                  32'({m_wr, m_rd, m_err, m_busy, m_wa, m_wd, m_ra, m_cnt}));
            if (o_Wr_En) wr_seen++;
            if (o_Rd_En) rd_seen++;
            if (o_Err_Pulse) err_seen++;
        end
    end

    task automatic send(input logic [7:0] b, input int hold, input int gap);
        @(negedge clk);
        i_RX_Byte = b;
        i_RX_DV   = 1'b1;
        repeat (hold) @(negedge clk);
        i_RX_DV = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic sendr(input logic [7:0] b);
        send(b, int'($urandom_range(1, 4)), int'($urandom_range(1, 3)));
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    typedef struct {
        int               n;
        logic [3:0][7:0]  b;
        int               d_wr, d_rd, d_err;
        logic [3:0]       wa;
        logic [7:0]       wd;
        logic [3:0]       ra;
        logic [7:0]       cnt;
    } vec_t;

    function automatic vec_t mk(input int n, input logic [7:0] b0, b1, b2, b3,
                                input int dw, dr, de, input logic [3:0] wa,
                                input logic [7:0] wd, input logic [3:0] ra, input logic [7:0] cnt);
        vec_t v;
        v.n = n; v.b = {b3, b2, b1, b0};
        v.d_wr = dw; v.d_rd = dr; v.d_err = de;
        v.wa = wa; v.wd = wd; v.ra = ra; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        vec_t       tbl[10];
        int         w0, r0, e0;
        logic [7:0] c, d, ck;

        tbl[0] = mk(4, 8'hA5, 8'h83, 8'h3C, 8'h1A, 1, 0, 0, 4'h3, 8'h3C, 4'h0, 8'd0);
        tbl[1] = mk(3, 8'hA5, 8'h05, 8'hA0, 8'h00, 0, 1, 0, 4'h3, 8'h3C, 4'h5, 8'd0);
        tbl[2] = mk(2, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 0, 0, 4'h3, 8'h3C, 4'h5, 8'd0);
        tbl[3] = mk(4, 8'hA5, 8'h83, 8'h3C, 8'h00, 0, 0, 1, 4'h3, 8'h3C, 4'h5, 8'd1);
        tbl[4] = mk(2, 8'hA5, 8'h93, 8'h00, 8'h00, 0, 0, 1, 4'h3, 8'h3C, 4'h5, 8'd2);
        tbl[5] = mk(4, 8'hA5, 8'h8F, 8'hFF, 8'hD5, 1, 0, 0, 4'hF, 8'hFF, 4'h5, 8'd2);
        tbl[6] = mk(3, 8'hA5, 8'h0A, 8'hAF, 8'h00, 0, 1, 0, 4'hF, 8'hFF, 4'hA, 8'd2);
        tbl[7] = mk(2, 8'hA5, 8'h70, 8'h00, 8'h00, 0, 0, 1, 4'hF, 8'hFF, 4'hA, 8'd3);
        tbl[8] = mk(4, 8'hA5, 8'h80, 8'h00, 8'h25, 1, 0, 0, 4'h0, 8'h00, 4'hA, 8'd3);
        tbl[9] = mk(2, 8'hA5, 8'hA5, 8'h00, 8'h00, 0, 0, 1, 4'h0, 8'h00, 4'hA, 8'd4);

        i_Reset = 1'b1; i_RX_DV = 1'b0; i_RX_Byte = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs",
              32'({o_Wr_En, o_Rd_En, o_Err_Pulse, o_Busy, o_Wr_Addr, o_Wr_Data, o_Rd_Addr, o_Err_Count}), 32'd0);
        i_Reset = 1'b0;

        // Frame table
        for (int i = 0; i < 10; i++) begin
            w0 = wr_seen; r0 = rd_seen; e0 = err_seen;
            for (int j = 0; j < tbl[i].n; j++) send(tbl[i].b[j], (i == 0) ? 217 : 3, 3);
            settle();
            check($sformatf("tbl%0d_wr", i),  32'(wr_seen - w0),  32'(tbl[i].d_wr));
            check($sformatf("tbl%0d_rd", i),  32'(rd_seen - r0),  32'(tbl[i].d_rd));
            check($sformatf("tbl%0d_err", i), 32'(err_seen - e0), 32'(tbl[i].d_err));
            check($sformatf("tbl%0d_wa", i),  32'(o_Wr_Addr),     32'(tbl[i].wa));
            check($sformatf("tbl%0d_wd", i),  32'(o_Wr_Data),     32'(tbl[i].wd));
            check($sformatf("tbl%0d_ra", i),  32'(o_Rd_Addr),     32'(tbl[i].ra));
            check($sformatf("tbl%0d_cnt", i), 32'(o_Err_Count),   32'(tbl[i].cnt));
            check($sformatf("tbl%0d_busy", i), 32'(o_Busy),       32'd0);
        end

        // Stall after CMD: timeout error, then a normal write still works
        w0 = wr_seen; e0 = err_seen;
        send(8'hA5, 2, 2); send(8'h83, 2, 2);
        repeat (TMO) @(negedge clk);
        settle();
        check("tmo_err",  32'(err_seen - e0), 32'd1);
        check("tmo_busy", 32'(o_Busy),        32'd0);
        send(8'hA5, 2, 2); send(8'h83, 2, 2); send(8'h3C, 2, 2); send(8'h1A, 2, 2);
        settle();
        check("tmo_then_wr", 32'(wr_seen - w0), 32'd1);

        // Next byte exactly on the timeout cycle is accepted
        w0 = wr_seen; e0 = err_seen;
        send(8'hA5, 2, 2); send(8'h83, 3, TMO - 3); send(8'h3C, 2, 2); send(8'h1A, 2, 2);
        settle();
        check("tmo_edge_wr",  32'(wr_seen - w0),  32'd1);
        check("tmo_edge_err", 32'(err_seen - e0), 32'd0);

        // One cycle later is too late
        e0 = err_seen;
        send(8'hA5, 2, 2); send(8'h83, 3, TMO - 2); send(8'h3C, 2, 2);
        settle();
        check("tmo_late_err",  32'(err_seen - e0), 32'd1);
        check("tmo_late_busy", 32'(o_Busy),        32'd0);

        // Reset mid-frame with DV held high through release
        w0 = wr_seen; e0 = err_seen;
        send(8'hA5, 2, 2);
        @(negedge clk); i_RX_Byte = 8'h83; i_RX_DV = 1'b1;
        @(negedge clk); i_Reset = 1'b1;
        repeat (2) @(negedge clk);
        i_Reset = 1'b0;
        @(negedge clk); #1;
        check("rst_mid_outputs",
              32'({o_Wr_En, o_Rd_En, o_Err_Pulse, o_Busy, o_Wr_Addr, o_Wr_Data, o_Rd_Addr, o_Err_Count}), 32'd0);
        repeat (3) @(negedge clk);
        i_RX_DV = 1'b0;
        send(8'h3C, 2, 2); send(8'h1A, 2, 2);
        settle();
        check("rst_mid_wr",   32'(wr_seen - w0),  32'd0);
        check("rst_mid_err",  32'(err_seen - e0), 32'd0);
        check("rst_mid_busy", 32'(o_Busy),        32'd0);

        // Error counter saturation
        e0 = err_seen; w0 = wr_seen;
        for (int i = 0; i < 260; i++) begin
            send(8'hA5, 1, 1); send(8'h01, 1, 1); send(8'h00, 1, 1);
        end
        settle();
        check("sat_pulses", 32'(err_seen - e0), 32'd260);
        check("sat_count",  32'(o_Err_Count),   32'd255);
        check("sat_no_wr",  32'(wr_seen - w0),  32'd0);

        // Randomized byte streams, checked by the model every cycle
        @(negedge clk); i_Reset = 1'b1;
        @(negedge clk); i_Reset = 1'b0;
        for (int it = 0; it < 250; it++) begin
            c = 8'(($urandom_range(0, 1) << 7) | $urandom_range(0, 15));
            d = 8'($urandom);
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    c[7] = 1'b1;
                    sendr(SYNC); sendr(c); sendr(d); sendr(SYNC ^ c ^ d);
                end
                3, 4: begin
                    c[7] = 1'b0;
                    sendr(SYNC); sendr(c); sendr(SYNC ^ c);
                end
                5: begin
                    c[7] = 1'b1;
                    ck = SYNC ^ c ^ d ^ 8'(1 << $urandom_range(0, 7));
                    sendr(SYNC); sendr(c); sendr(d); sendr(ck);
                end
                6: begin
                    c[6:4] = 3'($urandom_range(1, 7));
                    sendr(SYNC); sendr(c);
                end
                7: sendr(8'($urandom));
                8: begin
                    c[7] = 1'b1;
                    sendr(SYNC);
                    send(c, 2, TMO - 4 + int'($urandom_range(0, 6)));
                    sendr(d); sendr(SYNC ^ c ^ d);
                end
                9: begin
                    @(negedge clk);
                    i_Reset = 1'b1;
                    i_RX_DV = 1'($urandom_range(0, 1));
                    repeat ($urandom_range(1, 2)) @(negedge clk);
                    i_Reset = 1'b0;
                    repeat ($urandom_range(1, 3)) @(negedge clk);
                    i_RX_DV = 1'b0;
                end
                default: sendr(8'h00);
            endcase
        end
        repeat (TMO + 4) @(negedge clk);
        #1;
        check("end_idle", 32'(o_Busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
